id_ex_pipe_buffer: RTL and testbench

- Parametrised successor to the decode/execute pipeline register; sits between the decode stage and the execute stage of the core.
- Replaces the single flush/freeze register with a DEPTH-entry elastic buffer using valid/ready handshakes.
- Inserts hazard bubbles and counts them with a saturating counter.
- Each entry carries a control field (zeroed on bubble) and a data field (pc, status, operands, immediates, dest reg).

---
 rtl/id_ex_pipe_buffer.sv | 108 ++++++++++
 tb/tb_id_ex_pipe_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_buffer.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipe_buffer
// Description : Decode/execute elastic buffer with valid/ready handshakes,
//               hazard bubble insertion and a saturating bubble counter.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipe_buffer #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128,
    parameter int DEPTH  = 2,
    parameter int STAT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         freeze,
    input  logic                         hazard_detected,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_bubble,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [STAT_W-1:0]            bubble_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

    logic [CTRL_W-1:0] ctrl_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  bub_mem;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  count;

    logic              space;
    logic              advance;
    logic              do_enq;
    logic              do_deq;
    logic              not_empty;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign space     = (count < FULL_CNT);
    assign not_empty = (count != '0);
    assign advance   = !flush && !freeze;
    // A hazard always takes the slot, even without a valid instruction.
    assign do_enq    = advance && space && (hazard_detected || in_valid);
    assign do_deq    = advance && not_empty && out_ready;
    assign in_ready  = rst && space && !freeze && !flush && !hazard_detected;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            bubble_count <= '0;
            bub_mem      <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr          <= next_ptr(wr_ptr);
                bub_mem[wr_ptr] <= hazard_detected;
                if (hazard_detected && (bubble_count != '1)) begin
                    bubble_count <= bubble_count + 1'b1;
                end
            end
            if (do_deq) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_enq && !do_deq) begin
                count <= count + 1'b1;
            end else if (!do_enq && do_deq) begin
                count <= count - 1'b1;
            end
        end
    end

    // Payload storage needs no reset: the outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (rst && do_enq) begin
            ctrl_mem[wr_ptr] <= hazard_detected ? '0 : in_ctrl;
            data_mem[wr_ptr] <= in_data;
        end
    end

    assign out_valid  = not_empty;
    assign out_ctrl   = not_empty ? ctrl_mem[rd_ptr] : '0;
    assign out_data   = not_empty ? data_mem[rd_ptr] : '0;
    assign out_bubble = not_empty ? bub_mem[rd_ptr]  : 1'b0;
    assign occupancy  = count;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_pipe_buffer
// Description : Directed self-checking bench for id_ex_pipe_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush, freeze, hazard_detected, in_valid, out_ready;
    logic         in_ready, out_valid, out_bubble;
    logic [15:0]  in_ctrl, out_ctrl, bubble_count;
    logic [127:0] in_data, out_data;
    logic [1:0]   occupancy;

    logic         s_hazard, s_in_ready, s_out_valid, s_out_bubble;
    logic [15:0]  s_out_ctrl;
    logic [127:0] s_out_data;
    logic [1:0]   s_occupancy, s_bubble_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_pipe_buffer dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .hazard_detected(hazard_detected), .in_valid(in_valid),
        .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .out_bubble(out_bubble), .occupancy(occupancy),
        .bubble_count(bubble_count)
    );

    id_ex_pipe_buffer #(.STAT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .flush(1'b0), .freeze(1'b0),
        .hazard_detected(s_hazard), .in_valid(1'b0),
        .in_ready(s_in_ready), .in_ctrl(16'hFFFF), .in_data(128'h0),
        .out_valid(s_out_valid), .out_ready(1'b1), .out_ctrl(s_out_ctrl),
        .out_data(s_out_data), .out_bubble(s_out_bubble),
        .occupancy(s_occupancy), .bubble_count(s_bubble_count)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; freeze = 1'b0; hazard_detected = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0; in_ctrl = 16'h0033; in_data = 128'h3;
        s_hazard = 1'b0;

        // Reset held with a valid input present
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_bubble_count", bubble_count, 0);
        check("rst_out_data", out_data, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);

        // Fill to full, refuse a third entry, then drain
        in_valid = 1'b1; in_ctrl = 16'h0011; in_data = 128'hA;
        tick();
        check("fill1_occ", occupancy, 1);
        check("fill1_ctrl", out_ctrl, 16'h0011);
        in_ctrl = 16'h0022; in_data = 128'hB;
        tick();
        check("fill2_occ", occupancy, 2);
        check("fill2_in_ready", in_ready, 0);
        in_ctrl = 16'h0033; in_data = 128'hC;
        tick();
        check("full_occ", occupancy, 2);
        check("full_head", out_ctrl, 16'h0011);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("drain_head0", out_ctrl, 16'h0011);
        tick();
        check("drain_head1_ctrl", out_ctrl, 16'h0022);
        check("drain_head1_data", out_data, 128'hB);
        tick();
        check("drain_empty_valid", out_valid, 0);
        check("drain_empty_ctrl", out_ctrl, 0);

        // Refill after both pointers wrapped
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h0044; in_data = 128'hD;
        tick();
        check("wrap_ctrl", out_ctrl, 16'h0044);
        check("wrap_data", out_data, 128'hD);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("wrap_drain_occ", occupancy, 0);

        // Streaming with one-cycle latency
        in_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_ctrl = 16'(i); in_data = 128'(i);
            tick();
            check("stream_data", out_data, 128'(i));
            check("stream_occ", occupancy, 1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_occ", occupancy, 0);

        // Hazard bubble
        out_ready = 1'b0; hazard_detected = 1'b1; in_valid = 1'b1;
        in_ctrl = 16'hFFFF; in_data = 128'h55;
        #1;
        check("hz_in_ready", in_ready, 0);
        tick();
        check("hz_ctrl", out_ctrl, 0);
        check("hz_bubble", out_bubble, 1);
        check("hz_data", out_data, 128'h55);
        check("hz_count", bubble_count, 1);
        check("hz_occ", occupancy, 1);
        hazard_detected = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("hz_drain_occ", occupancy, 0);

        // Saturating counter on the narrow instance
        s_hazard = 1'b1;
        repeat (2) tick();
        check("sat_count2", s_bubble_count, 2);
        repeat (3) tick();
        check("sat_count5", s_bubble_count, 3);
        s_hazard = 1'b0;

        // Freeze holds everything, then flush overrides freeze
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h0066; in_data = 128'h6;
        tick();
        in_ctrl = 16'h0077; in_data = 128'h7;
        tick();
        in_valid = 1'b0; freeze = 1'b1; out_ready = 1'b1; hazard_detected = 1'b1;
        repeat (3) tick();
        check("frz_head", out_ctrl, 16'h0066);
        check("frz_occ", occupancy, 2);
        check("frz_valid", out_valid, 1);
        check("frz_bcount", bubble_count, 1);
        hazard_detected = 1'b0;
        flush = 1'b1; in_valid = 1'b1; in_ctrl = 16'h0088;
        tick();
        check("fl_occ", occupancy, 0);
        check("fl_valid", out_valid, 0);
        check("fl_ctrl", out_ctrl, 0);
        check("fl_bcount", bubble_count, 1);
        flush = 1'b0; freeze = 1'b0; in_valid = 1'b0;

        // Full with simultaneous request: no pass-through
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h0091;
        tick();
        in_ctrl = 16'h0092;
        tick();
        in_ctrl = 16'h0093; out_ready = 1'b1;
        #1;
        check("fs_in_ready", in_ready, 0);
        tick();
        check("fs_occ1", occupancy, 1);
        check("fs_head1", out_ctrl, 16'h0092);
        tick();
        check("fs_occ2", occupancy, 1);
        check("fs_head2", out_ctrl, 16'h0093);

        // Hazard while full inserts nothing
        out_ready = 1'b0; in_ctrl = 16'h00A5;
        tick();
        in_valid = 1'b0; hazard_detected = 1'b1;
        tick();
        check("hzf_occ", occupancy, 2);
        check("hzf_bcount", bubble_count, 1);
        check("hzf_head", out_ctrl, 16'h0093);
        hazard_detected = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
